// File: rtl/rssi_tune_scanner.sv
// Channel sweep controller: retunes, settles, discards and averages RSSI window
// sums per channel, then publishes the strongest channel and a lock flag.
//
// state   | meaning
// IDLE    | waiting for start; published results held
// TUNE    | channel just changed, accumulator gated off while it settles
// DISCARD | dropping the first window sums after settle
// ACCUM   | summing 2^AVG_LOG2 window sums for the current channel
// COMPARE | fold channel sum into working best, advance channel
// DONE    | publish working best to outputs
module rssi_tune_scanner #(
  parameter int NUM_CH     = 8,
  parameter int CH_W       = 3,
  parameter int SUM_W      = 27,
  parameter int SETTLE_CYC = 16,
  parameter int N_DISCARD  = 1,
  parameter int AVG_LOG2   = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [SUM_W+AVG_LOG2-1:0] threshold,
  input  logic [SUM_W-1:0]          sum_in,
  input  logic                      sum_valid,
  output logic [CH_W-1:0]           channel,
  output logic                      rssi_en,
  output logic                      busy,
  output logic                      done,
  output logic [CH_W-1:0]           best_ch,
  output logic [SUM_W+AVG_LOG2-1:0] best_sum,
  output logic                      locked
);

  localparam int ACC_W = SUM_W + AVG_LOG2;
  localparam int N_AVG = 1 << AVG_LOG2;
  localparam int CNT_W = $clog2(SETTLE_CYC + N_AVG + 4);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DISC_LD   = CNT_W'((N_DISCARD > 0) ? N_DISCARD - 1 : 0);
  localparam logic [CNT_W-1:0] AVG_LD    = CNT_W'(N_AVG - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TUNE, S_DISCARD, S_ACCUM, S_COMPARE, S_DONE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ACC_W-1:0] acc, acc_d, wbest_sum, wbest_sum_d, best_sum_d;
  logic [CH_W-1:0]  wbest_ch, wbest_ch_d, channel_d, best_ch_d;
  logic             first, first_d, rssi_en_d, busy_d, done_d, locked_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      wbest_sum <= '0;
      wbest_ch  <= '0;
      first     <= 1'b0;
      channel   <= '0;
      rssi_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      best_ch   <= '0;
      best_sum  <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      acc       <= acc_d;
      wbest_sum <= wbest_sum_d;
      wbest_ch  <= wbest_ch_d;
      first     <= first_d;
      channel   <= channel_d;
      rssi_en   <= rssi_en_d;
      busy      <= busy_d;
      done      <= done_d;
      best_ch   <= best_ch_d;
      best_sum  <= best_sum_d;
      locked    <= locked_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    acc_d       = acc;
    wbest_sum_d = wbest_sum;
    wbest_ch_d  = wbest_ch;
    first_d     = first;
    channel_d   = channel;
    best_ch_d   = best_ch;
    best_sum_d  = best_sum;
    locked_d    = locked;
    done_d      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d     = S_TUNE;
          channel_d   = '0;
          cnt_d       = SETTLE_LD;
          acc_d       = '0;
          wbest_sum_d = '0;
          wbest_ch_d  = '0;
          first_d     = 1'b1;
        end
      end
      S_TUNE: begin
        if (cnt == '0) begin
          if (N_DISCARD == 0) begin
            state_d = S_ACCUM;
            cnt_d   = AVG_LD;
          end else begin
            state_d = S_DISCARD;
            cnt_d   = DISC_LD;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_DISCARD: begin
        if (sum_valid) begin
          if (cnt == '0) begin
            state_d = S_ACCUM;
            cnt_d   = AVG_LD;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (sum_valid) begin
          acc_d = acc + ACC_W'(sum_in);
          if (cnt == '0) state_d = S_COMPARE;
          else           cnt_d   = cnt - 1'b1;
        end
      end
      S_COMPARE: begin
        // strict > so a tie keeps the lower-numbered channel
        if (first || (acc > wbest_sum)) begin
          wbest_sum_d = acc;
          wbest_ch_d  = channel;
        end
        first_d = 1'b0;
        acc_d   = '0;
        if (channel == LAST_CH) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_TUNE;
          channel_d = channel + 1'b1;
          cnt_d     = SETTLE_LD;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        best_ch_d  = wbest_ch;
        best_sum_d = wbest_sum;
        locked_d   = (wbest_sum >= threshold);
        done_d     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // abort wins over everything, including a start in the same cycle
    if (abort) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      best_ch_d  = best_ch;
      best_sum_d = best_sum;
      locked_d   = locked;
    end

    busy_d    = state_d inside {S_TUNE, S_DISCARD, S_ACCUM, S_COMPARE};
    rssi_en_d = state_d inside {S_DISCARD, S_ACCUM};
  end

endmodule

// File: doc/rssi_tune_scanner.md
Name: rssi_tune_scanner

Overview:
- Consumer side of the tune-detector RSSI path: sweeps the tuner over NUM_CH channels and gates the RSSI window accumulator on each one.
- Collects its per-window energy sums and reports the strongest channel plus a lock flag.
- Sits between the RSSI window accumulator (sum source) and the tuner channel select / control registers.

Parameters:
- NUM_CH, 8, channels swept, indices 0..NUM_CH-1 (2..8)
- CH_W, 3, channel index width
- SUM_W, 27, width of the incoming window sum
- SETTLE_CYC, 16, clk cycles rssi_en is held low after each retune (>=1)
- N_DISCARD, 1, window sums dropped after settle (0..3)
- AVG_LOG2, 2, 2^AVG_LOG2 window sums accumulated per channel

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous active-low
- start  in  1  one-cycle pulse, begins a sweep when idle
- abort  in  1  level; returns to IDLE
- threshold  in  SUM_W+AVG_LOG2  lock threshold on the accumulated channel sum
- sum_in  in  SUM_W  window sum from the RSSI accumulator
- sum_valid  in  1  one-cycle strobe; sum_in is a new completed window
- channel  out  CH_W  tuner channel select
- rssi_en  out  1  enable to the RSSI accumulator
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- best_ch  out  CH_W  strongest channel of the last completed sweep
- best_sum  out  SUM_W+AVG_LOG2  accumulated sum of best_ch
- locked  out  1  best_sum >= threshold, last completed sweep

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; channel, best_ch, best_sum = 0; rssi_en, busy, done, locked = 0; all counters and the accumulator = 0.
- Registers: every output is registered.
- States: IDLE -> TUNE -> DISCARD -> ACCUM -> COMPARE -> (TUNE next channel | DONE) -> IDLE.
- IDLE:
  - start=1 -> TUNE with channel=0.
  - Clear the working best (wbest_sum=0, wbest_ch=0, first=1).
  - busy=1 from the next cycle.
  - Published best_ch, best_sum and locked are unchanged until DONE.
- TUNE:
  - rssi_en=0; the settle counter counts SETTLE_CYC cycles.
  - Then -> DISCARD, or -> ACCUM if N_DISCARD=0.
  - rssi_en=1 from the cycle the state is entered.
- DISCARD: count sum_valid strobes; after N_DISCARD strobes -> ACCUM. The sum_in values are ignored.
- ACCUM:
  - On each sum_valid, acc += sum_in (width SUM_W+AVG_LOG2, zero-extended, no overflow possible).
  - After 2^AVG_LOG2 strobes -> COMPARE. The final strobe is included in acc.
- COMPARE (1 cycle):
  - rssi_en=0.
  - If first=1 or acc > wbest_sum: update wbest_sum=acc and wbest_ch=channel. Strict > means ties keep the lower channel.
  - Clear first and acc.
  - If channel==NUM_CH-1 -> DONE; else channel+1 and -> TUNE.
- DONE (1 cycle):
  - best_ch=wbest_ch, best_sum=wbest_sum, locked=(wbest_sum>=threshold); done=1 for this cycle only.
  - busy=0 and channel held at its last value.
  - -> IDLE.
- sum_valid outside DISCARD/ACCUM: ignored.
- start while busy: ignored.
- start in the DONE cycle: ignored; start is accepted from IDLE only.
- abort=1, any state except IDLE:
  - Next state IDLE; rssi_en=0, busy=0, no done.
  - Working values are discarded; published best_* and locked are retained.
  - abort has priority over start.
- Reset mid-sweep: same as power-on reset; published results are cleared.
- Latency from start to done: NUM_CH*(SETTLE_CYC + COMPARE cycle + time to N_DISCARD+2^AVG_LOG2 strobes) + 2 cycles. No fixed bound, since it depends on the sum_valid rate.

Test Plan:
- Baseline sweep, defaults: each channel c returns sum_in=1000*(c+1) on every strobe. Expect done after 8 channels, best_ch=7, best_sum=32000; locked=1 with threshold=32000, locked=0 with threshold=32001.
- Tie: channels 2 and 5 return 5000 and all others return 100. Expect best_ch=2, best_sum=20000.
- Discard/settle: first strobe after each retune = 27'h7FFFFFF, later strobes = 10. Expect best_sum=40 on all channels and best_ch=0. Check rssi_en low for exactly 16 cycles after every channel change.
- Ignored events: pulse start mid-sweep and sum_valid during TUNE/COMPARE. Expect the sweep unaffected, exactly one done, accumulated sums unchanged.
- Abort: after a full sweep (best_ch=7), start again and assert abort during channel 3 ACCUM. Expect IDLE next cycle, rssi_en=0, busy=0, no done, best_ch still 7; a new start then completes normally.
- Reset mid-sweep: rstn=0 for one cycle during channel 4. Expect all outputs 0 on the next cycle and start accepted afterward.
